// File: rtl/router_pkg.sv
// Shared definitions for the router packet source.
//   ADDR_W / LEN_W / DATA_W : field widths of the router packet format
//   ADDR_INVALID            : destination code that has no router output port
//   tx_state_t              : transmit sequencer states
//   make_header()           : builds the header byte {len, addr}
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer for router_pkt_tx.
// One entry per possible payload byte, written as bytes arrive from the local
// stream and read back during transmission. Storage is not reset: the write
// pointer restarts at 0 for each packet, so stale contents are never read.
//   clock   : rising-edge clock
//   wr_en   : write wr_data into entry wr_addr at the next edge
//   wr_addr : write index
//   wr_data : byte to store
//   rd_addr : read index
//   rd_data : contents of entry rd_addr (combinational read)
module router_tx_buf #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** LEN_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source driving the 1x3 router input port.
// A request (destination, payload length) is accepted in IDLE, the whole
// payload is collected from the local byte stream, then header, payload and
// parity are sent on pkt_valid/data_out, holding each byte while busy is high.
//   clock, reset   : clock and synchronous active-high reset
//   pkt_req/addr/len : packet request, sampled in IDLE only
//   pkt_ack, req_err : one-cycle accept / reject pulses
//   pl_data/valid/ready : local payload byte stream
//   busy           : router back-pressure
//   pkt_valid, data_out : router input port
//   tx_active      : sequencer not idle
//   tx_done        : one-cycle pulse after the parity byte is consumed
module router_pkt_tx #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_req,
    input  logic [1:0]        pkt_addr,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_ack,
    output logic              req_err,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_active,
    output logic              tx_done
);

    import router_pkg::tx_state_t, router_pkg::make_header, router_pkg::ADDR_INVALID;
    import router_pkg::IDLE, router_pkg::FILL, router_pkg::HEADER;
    import router_pkg::PAYLOAD, router_pkg::PARITY, router_pkg::GAP;

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_t         state_reg, state_next;
    logic [1:0]        addr_reg, addr_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [LEN_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0] parity_reg, parity_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic              pkt_ack_reg, pkt_ack_next;
    logic              req_err_reg, req_err_next;
    logic              tx_done_reg, tx_done_next;

    logic              buf_wr_en;
    logic [DATA_W-1:0] buf_rd_data;
    logic [LEN_W-1:0]  last_idx;
    logic [DATA_W-1:0] header_byte;

    assign last_idx    = len_reg - LEN_W'(1);
    assign header_byte = make_header(len_reg, addr_reg);

    router_tx_buf #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (pl_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            len_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            parity_reg  <= '0;
            gap_cnt_reg <= '0;
            pkt_ack_reg <= 1'b0;
            req_err_reg <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            len_reg     <= len_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            parity_reg  <= parity_next;
            gap_cnt_reg <= gap_cnt_next;
            pkt_ack_reg <= pkt_ack_next;
            req_err_reg <= req_err_next;
            tx_done_reg <= tx_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        len_next     = len_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        parity_next  = parity_reg;
        gap_cnt_next = gap_cnt_reg;
        pkt_ack_next = 1'b0;
        req_err_next = 1'b0;
        tx_done_next = 1'b0;
        buf_wr_en    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pkt_req) begin
                    if (pkt_addr == ADDR_INVALID || pkt_len == '0) begin
                        req_err_next = 1'b1;
                    end else begin
                        addr_next    = pkt_addr;
                        len_next     = pkt_len;
                        // Parity accumulation starts from the header byte.
                        parity_next  = make_header(pkt_len, pkt_addr);
                        wr_ptr_next  = '0;
                        pkt_ack_next = 1'b1;
                        state_next   = FILL;
                    end
                end
            end
            FILL: begin
                // pl_ready is constantly high here, so pl_valid alone marks a transfer.
                if (pl_valid) begin
                    buf_wr_en   = 1'b1;
                    parity_next = parity_reg ^ pl_data;
                    wr_ptr_next = wr_ptr_reg + LEN_W'(1);
                    if (wr_ptr_reg == last_idx) begin
                        state_next = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    rd_ptr_next = '0;
                    state_next  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (rd_ptr_reg == last_idx) begin
                        state_next = PARITY;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + LEN_W'(1);
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    gap_cnt_next = GAP_W'(GAP_CYCLES);
                    tx_done_next = 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                // The counter is loaded with the gap length, so leaving at 1 gives
                // exactly GAP_CYCLES idle-line cycles.
                if (gap_cnt_reg <= GAP_W'(1)) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state and buffer contents.
    always_comb begin
        pkt_valid = 1'b0;
        data_out  = '0;
        case (state_reg)
            HEADER: begin
                pkt_valid = 1'b1;
                data_out  = header_byte;
            end
            PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = buf_rd_data;
            end
            PARITY: begin
                data_out = parity_reg;
            end
            default: begin
                pkt_valid = 1'b0;
                data_out  = '0;
            end
        endcase
    end

    assign pl_ready  = (state_reg == FILL);
    assign tx_active = (state_reg != IDLE);
    assign pkt_ack   = pkt_ack_reg;
    assign req_err   = req_err_reg;
    assign tx_done   = tx_done_reg;

endmodule
